// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   SEG_OFF     : active-low segment pattern with every segment dark
//   seg_state_e : slot phase, blanking gap or digit drive
//   clog2       : ceiling log2 used to size index/counter registers
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_e;

  // Ceiling log2, never less than 1 so the result can size a register
  function automatic int clog2(input int unsigned v);
    int r;
    r = 32'sd1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Nibble to hex glyph decoder, shared by all digits.
//   nibble : 4-bit hex value
//   seg    : segments a..g as [0]..[6], active-high (1 = lit)
module seg_hex_dec (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Standard hex glyph table (b and d lower-case)
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_tick.sv
// Digit slot timer: counts CLK_DIV cycles per slot, the first BLANK_CYC
// of them in ST_BLANK and the rest in ST_DRIVE.
//   clk, reset_n : clock, asynchronous active-low reset
//   state        : current slot phase (registered)
//   slot_end     : high during the last cycle of a slot
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  output seg_state_e state,
  output logic       slot_end
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  seg_state_e       state_r;

  // Slot counter and phase; DRIVE starts once the blanking gap has elapsed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      state_r <= ST_BLANK;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      state_r <= ST_BLANK;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == BLANK_LAST) begin
        state_r <= ST_DRIVE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign state    = state_r;
  assign slot_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment display controller with double-buffered
// hex value, frame-boundary swap and optional leading-zero suppression.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : strobe, capture value/dp_in into the pending buffer
//   value        : packed nibbles, nibble 0 = rightmost digit
//   dp_in        : decimal point per digit, 1 = lit
//   lz_suppress  : blank leading zeros, sampled at frame swap
//   load_ack     : one-cycle pulse when pending data is taken for display
//   dig_sel_n    : active-low digit enables, at most one low
//   seg_n, dp_n  : active-low segments a..g and decimal point
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_suppress,
  output logic                  load_ack,
  output logic [N_DIGITS-1:0]   dig_sel_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  localparam int IDX_W = clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  seg_state_e            state_s;
  logic                  slot_end_s;
  logic [IDX_W-1:0]      idx_r;
  logic [4*N_DIGITS-1:0] disp_val_r;
  logic [N_DIGITS-1:0]   disp_dp_r;
  logic                  lz_r;
  logic [4*N_DIGITS-1:0] pend_val_r;
  logic [N_DIGITS-1:0]   pend_dp_r;
  logic                  pend_r;
  logic                  ack_r;
  logic [N_DIGITS-1:0]   dig_sel_n_r;
  logic [6:0]            seg_n_r;
  logic                  dp_n_r;
  logic                  swap_s;
  logic [3:0]            nib_s;
  logic [6:0]            glyph_s;
  logic                  dp_sel_s;
  logic [N_DIGITS-1:0]   blank_mask_s;
  logic [N_DIGITS-1:0]   onehot_s;
  logic                  zero_above_s;
  logic                  show_s;

  seg_scan_tick #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (state_s),
    .slot_end(slot_end_s)
  );

  // Swap only on the last cycle of the last digit, so a frame never tears
  assign swap_s = slot_end_s && (idx_r == IDX_LAST) && pend_r;

  assign nib_s    = disp_val_r[{idx_r, 2'b00} +: 4];
  assign dp_sel_s = disp_dp_r[idx_r];

  seg_hex_dec u_dec (
    .nibble(nib_s),
    .seg   (glyph_s)
  );

  // Leading-zero mask: digit k blanked when it and every higher nibble is zero
  always_comb begin
    blank_mask_s = '0;
    zero_above_s = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s && (disp_val_r[4*k +: 4] == 4'h0);
      if (lz_r && (k != 0) && zero_above_s) begin
        blank_mask_s[k] = 1'b1;
      end else begin
        blank_mask_s[k] = 1'b0;
      end
    end
  end

  // One-hot of the current digit index
  always_comb begin
    onehot_s        = '0;
    onehot_s[idx_r] = 1'b1;
  end

  assign show_s = (state_s == ST_DRIVE) && !blank_mask_s[idx_r];

  // Digit index advances at every slot end, wrapping after the last digit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= '0;
    end else if (slot_end_s) begin
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Pending/display buffers; a load on the swap cycle stays pending for the next frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_val_r <= '0;
      pend_dp_r  <= '0;
      pend_r     <= 1'b0;
      disp_val_r <= '0;
      disp_dp_r  <= '0;
      lz_r       <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      if (load) begin
        pend_val_r <= value;
        pend_dp_r  <= dp_in;
      end else begin
        pend_val_r <= pend_val_r;
        pend_dp_r  <= pend_dp_r;
      end
      if (swap_s) begin
        disp_val_r <= pend_val_r;
        disp_dp_r  <= pend_dp_r;
        lz_r       <= lz_suppress;
      end else begin
        disp_val_r <= disp_val_r;
        disp_dp_r  <= disp_dp_r;
        lz_r       <= lz_r;
      end
      pend_r <= load ? 1'b1 : (swap_s ? 1'b0 : pend_r);
      ack_r  <= swap_s;
    end
  end

  // Registered pin drivers, everything dark unless the digit is being shown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_sel_n_r <= '1;
      seg_n_r     <= SEG_OFF;
      dp_n_r      <= 1'b1;
    end else if (show_s) begin
      dig_sel_n_r <= ~onehot_s;
      seg_n_r     <= ~glyph_s;
      dp_n_r      <= ~dp_sel_s;
    end else begin
      dig_sel_n_r <= '1;
      seg_n_r     <= SEG_OFF;
      dp_n_r      <= 1'b1;
    end
  end

  assign load_ack  = ack_r;
  assign dig_sel_n = dig_sel_n_r;
  assign seg_n     = seg_n_r;
  assign dp_n      = dp_n_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int N_DIGITS  = 4;
  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = N_DIGITS * CLK_DIV;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic        lz;
    int          tgt;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic        load_ack;
  logic [3:0]  dig_sel_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  int     total = 0;
  int     bad = 0;
  int     n;
  frame_t exp_q[$];
  frame_t cur;

  seg_scan_ctrl #(
    .N_DIGITS (N_DIGITS),
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_suppress(lz_suppress),
    .load_ack   (load_ack),
    .dig_sel_n  (dig_sel_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  always #5 clk = ~clk;

  // Posedges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  // Active-low hex glyphs
  function automatic logic [6:0] glyph_n(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Expected {dig_sel_n, seg_n, dp_n} after posedge nn showing frame f
  function automatic logic [11:0] exp_pins(input int nn, input frame_t f);
    int s, p, k;
    logic [15:0] above;
    logic [3:0]  oh;
    if (nn < 3) return {4'hF, 7'h7F, 1'b1};
    s = (nn - 3) / CLK_DIV;
    p = (nn - 3) % CLK_DIV;
    if (p >= CLK_DIV - BLANK_CYC) return {4'hF, 7'h7F, 1'b1};
    k = s % N_DIGITS;
    above = f.v >> (4 * k);
    if (f.lz && k != 0 && above == 16'h0000) return {4'hF, 7'h7F, 1'b1};
    oh = 4'b0001 << k;
    return {~oh, glyph_n(above[3:0]), ~f.dp[k]};
  endfunction

  // Output monitor: compare pins each cycle, pop scoreboard at frame boundaries
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pins", 32'({dig_sel_n, seg_n, dp_n}), 32'(exp_pins(n, cur)));
      chk("onehot", 32'($countones(~dig_sel_n) <= 1), 32'd1);
      if (n > 0 && n % FRAME == 0) begin
        if (exp_q.size() > 0 && exp_q[0].tgt == n / FRAME) begin
          chk("ack", 32'(load_ack), 32'd1);
          cur = exp_q.pop_front();
        end else begin
          chk("ack_none", 32'(load_ack), 32'd0);
        end
      end else if (load_ack) begin
        chk("ack_spur", 32'(load_ack), 32'd0);
      end
    end
  end

  // Drive one load strobe; the data appears in the first frame starting after it is sampled
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    frame_t e;
    int     p;
    load = 1'b1; value = v; dp_in = dp; lz_suppress = lz;
    p = n + 1;
    e.v = v; e.dp = dp; e.lz = lz; e.tgt = p / FRAME + 1;
    if (exp_q.size() > 0 && exp_q[$].tgt == e.tgt) void'(exp_q.pop_back());
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic goto(input int nn);
    int g;
    g = 0;
    while (n < nn && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("sync", 32'(n), 32'(nn));
  endtask

  initial begin
    cur.v = 16'h0000; cur.dp = 4'h0; cur.lz = 1'b0; cur.tgt = 0;
    #23;
    chk("rst_pins", 32'({dig_sel_n, seg_n, dp_n}), 32'hFFF);
    chk("rst_ack", 32'(load_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "0000" with LZ off for two frames
    goto(64);
    // Mid-frame load, shown from frame 3
    goto(70);
    do_load(16'h12AF, 4'b0100, 1'b0);
    // Three loads in one frame, last wins
    goto(100); do_load(16'h1111, 4'h0, 1'b0);
    goto(108); do_load(16'h2222, 4'h0, 1'b0);
    goto(116); do_load(16'h3333, 4'h0, 1'b0);
    // Leading-zero suppression
    goto(135); do_load(16'h0005, 4'b1111, 1'b1);
    goto(165); do_load(16'h0000, 4'h0, 1'b1);
    // Load on the exact swap cycle with AAAA already pending
    goto(200); do_load(16'hAAAA, 4'h0, 1'b0);
    goto(223); do_load(16'hBBBB, 4'h0, 1'b0);
    // Reset during DRIVE with a load pending
    goto(292); do_load(16'h1234, 4'h1, 1'b0);
    goto(300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pins", 32'({dig_sel_n, seg_n, dp_n}), 32'hFFF);
    chk("rst_mid_ack", 32'(load_ack), 32'd0);
    exp_q.delete();
    cur.v = 16'h0000; cur.dp = 4'h0; cur.lz = 1'b0; cur.tgt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    goto(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
